// File: rtl/env_pkg.sv
// Shared definitions for the multi-channel ADSR envelope: channel state encoding
// and the rate-to-accumulator-increment helper.
package env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    // Rate code that forces a step on every qualified cycle.
    localparam logic [3:0] RATE_FAST = 4'hF;

    // Accumulator increment is 1 << rate_exp(); rates beyond the accumulator
    // width are pinned to its top bit.
    function automatic logic [4:0] rate_exp(input logic [3:0] rate, input logic [5:0] timer_w);
        logic [4:0] exp_v;
        if ({2'b00, rate} >= timer_w) begin
            exp_v = 5'(timer_w - 6'd1);
        end else begin
            exp_v = {1'b0, rate};
        end
        return exp_v;
    endfunction

endpackage

// File: rtl/env_adsr_ch.sv
// Single ADSR envelope channel: rate accumulator, gate/retrigger handling and a
// registered level/active output stage.
module env_adsr_ch
    import env_pkg::*;
#(
    parameter int VEL_W   = 7,
    parameter int TIMER_W = 26,
    parameter int STEP    = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [3:0]       attack_i,
    input  logic [3:0]       decay_i,
    input  logic [VEL_W-1:0] sustain_i,
    input  logic [3:0]       release_rate_i,
    input  logic             note_on_i,
    input  logic             note_repeat_i,
    input  logic [6:0]       note_i,
    input  logic [VEL_W-1:0] vel_i,
    output logic [VEL_W-1:0] level_o,
    output logic             active_o
);

    localparam logic [VEL_W:0]     STEP_X  = (VEL_W + 1)'(STEP);
    localparam logic [TIMER_W-1:0] ACC_ONE = TIMER_W'(1);

    env_state_e         state_q;
    logic [VEL_W-1:0]   level_q;
    logic [VEL_W-1:0]   peak_q;
    logic [6:0]         note_q;
    logic [TIMER_W-1:0] acc_q;
    logic [VEL_W-1:0]   level_out_q;
    logic               active_out_q;

    logic [3:0]         rate_s;
    logic [TIMER_W-1:0] inc_s;
    logic [TIMER_W:0]   acc_sum_s;
    logic [TIMER_W-1:0] acc_d;
    logic               step_s;
    logic               retrig_s;
    logic [VEL_W:0]     level_x;
    logic [VEL_W:0]     peak_x;
    logic [VEL_W:0]     target_x;
    logic [VEL_W:0]     up_s;
    logic [VEL_W:0]     dec_s;
    logic [VEL_W:0]     rel_s;

    // Rate accumulator, step detection and the saturating next-level candidates.
    always_comb begin
        case (state_q)
            ST_ATTACK:  rate_s = attack_i;
            ST_DECAY:   rate_s = decay_i;
            ST_RELEASE: rate_s = release_rate_i;
            default:    rate_s = RATE_FAST;
        endcase

        inc_s     = ACC_ONE << rate_exp(rate_s, 6'(TIMER_W));
        acc_sum_s = {1'b0, acc_q} + {1'b0, inc_s};
        if (rate_s == RATE_FAST) begin
            step_s = 1'b1;
            acc_d  = '0;
        end else begin
            step_s = acc_sum_s[TIMER_W];
            acc_d  = acc_sum_s[TIMER_W-1:0];
        end

        level_x = {1'b0, level_q};
        peak_x  = {1'b0, peak_q};
        if (sustain_i < peak_q) begin
            target_x = {1'b0, sustain_i};
        end else begin
            target_x = peak_x;
        end

        // Each candidate is only consumed when its difference cannot underflow.
        if ((peak_x - level_x) > STEP_X) begin
            up_s = level_x + STEP_X;
        end else begin
            up_s = peak_x;
        end
        if ((level_x - target_x) > STEP_X) begin
            dec_s = level_x - STEP_X;
        end else begin
            dec_s = target_x;
        end
        if (level_x > STEP_X) begin
            rel_s = level_x - STEP_X;
        end else begin
            rel_s = '0;
        end

        retrig_s = note_on_i & (note_repeat_i | (note_i != note_q));
    end

    // Envelope FSM plus the output register stage that lags it by one clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            peak_q       <= '0;
            note_q       <= 7'd0;
            acc_q        <= '0;
            level_out_q  <= '0;
            active_out_q <= 1'b0;
        end else begin
            level_out_q  <= level_q;
            active_out_q <= (state_q != ST_IDLE);
            if (en_i) begin
                if (state_q == ST_IDLE) begin
                    if (note_on_i) begin
                        state_q <= ST_ATTACK;
                        note_q  <= note_i;
                        peak_q  <= vel_i;
                        acc_q   <= '0;
                    end
                end else if (retrig_s) begin
                    // Level is kept so a retrigger never jumps the output.
                    state_q <= ST_ATTACK;
                    note_q  <= note_i;
                    peak_q  <= vel_i;
                    acc_q   <= '0;
                end else if (!note_on_i && (state_q != ST_RELEASE)) begin
                    state_q <= ST_RELEASE;
                    acc_q   <= '0;
                end else begin
                    case (state_q)
                        ST_ATTACK: begin
                            if (level_x >= peak_x) begin
                                state_q <= ST_DECAY;
                                acc_q   <= '0;
                            end else if (step_s) begin
                                level_q <= up_s[VEL_W-1:0];
                                if (up_s == peak_x) begin
                                    state_q <= ST_DECAY;
                                    acc_q   <= '0;
                                end else begin
                                    acc_q <= acc_d;
                                end
                            end else begin
                                acc_q <= acc_d;
                            end
                        end
                        ST_DECAY: begin
                            if (level_x <= target_x) begin
                                state_q <= ST_SUSTAIN;
                                acc_q   <= '0;
                            end else if (step_s) begin
                                level_q <= dec_s[VEL_W-1:0];
                                if (dec_s == target_x) begin
                                    state_q <= ST_SUSTAIN;
                                    acc_q   <= '0;
                                end else begin
                                    acc_q <= acc_d;
                                end
                            end else begin
                                acc_q <= acc_d;
                            end
                        end
                        ST_RELEASE: begin
                            if (level_q == '0) begin
                                state_q <= ST_IDLE;
                                acc_q   <= '0;
                            end else if (step_s) begin
                                level_q <= rel_s[VEL_W-1:0];
                                if (rel_s == '0) begin
                                    state_q <= ST_IDLE;
                                    acc_q   <= '0;
                                end else begin
                                    acc_q <= acc_d;
                                end
                            end else begin
                                acc_q <= acc_d;
                            end
                        end
                        default: begin
                            state_q <= state_q;
                        end
                    endcase
                end
            end
        end
    end

    assign level_o  = level_out_q;
    assign active_o = active_out_q;

endmodule

// File: rtl/env_adsr_multi.sv
// Multi-channel ADSR envelope generator: one env_adsr_ch per channel, with the
// top level only slicing the packed per-channel buses.
module env_adsr_multi
    import env_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int VEL_W    = 7,
    parameter int TIMER_W  = 26,
    parameter int STEP     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [3:0]                attack,
    input  logic [3:0]                decay,
    input  logic [VEL_W-1:0]          sustain,
    input  logic [3:0]                release_rate,
    input  logic [CHANNELS-1:0]       note_on,
    input  logic [CHANNELS-1:0]       note_repeat,
    input  logic [7*CHANNELS-1:0]     note_start,
    input  logic [VEL_W*CHANNELS-1:0] vel_start,
    output logic [VEL_W*CHANNELS-1:0] adjusted_vel,
    output logic [CHANNELS-1:0]       active
);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            env_adsr_ch #(
                .VEL_W  (VEL_W),
                .TIMER_W(TIMER_W),
                .STEP   (STEP)
            ) u_ch (
                .clk_i         (clk),
                .rst_n_i       (rst_n),
                .en_i          (en),
                .attack_i      (attack),
                .decay_i       (decay),
                .sustain_i     (sustain),
                .release_rate_i(release_rate),
                .note_on_i     (note_on[g]),
                .note_repeat_i (note_repeat[g]),
                .note_i        (note_start[7*g +: 7]),
                .vel_i         (vel_start[VEL_W*g +: VEL_W]),
                .level_o       (adjusted_vel[VEL_W*g +: VEL_W]),
                .active_o      (active[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_env_adsr_multi.sv
// Self-checking bench for env_adsr_multi: directed scenarios followed by random
// gate/velocity traffic, all compared against a behavioural envelope model.
module tb_env_adsr_multi;

    localparam int CH = 4;
    localparam int VW = 7;
    localparam int TW = 8;
    localparam int ST = 8;

    localparam int P_OFF  = 0;
    localparam int P_RISE = 1;
    localparam int P_FALL = 2;
    localparam int P_HOLD = 3;
    localparam int P_FADE = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [3:0]       attack;
    logic [3:0]       decay;
    logic [VW-1:0]    sustain;
    logic [3:0]       release_rate;
    logic [CH-1:0]    note_on;
    logic [CH-1:0]    note_repeat;
    logic [7*CH-1:0]  note_start;
    logic [VW*CH-1:0] vel_start;
    logic [VW*CH-1:0] adjusted_vel;
    logic [CH-1:0]    active;

    int     m_ph   [CH];
    int     m_lvl  [CH];
    int     m_note [CH];
    int     m_peak [CH];
    longint m_acc  [CH];
    int     exp_vel[CH];
    int     exp_act[CH];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    env_adsr_multi #(
        .CHANNELS(CH),
        .VEL_W   (VW),
        .TIMER_W (TW),
        .STEP    (ST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .attack      (attack),
        .decay       (decay),
        .sustain     (sustain),
        .release_rate(release_rate),
        .note_on     (note_on),
        .note_repeat (note_repeat),
        .note_start  (note_start),
        .vel_start   (vel_start),
        .adjusted_vel(adjusted_vel),
        .active      (active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic logic [31:0] ch_vel(input int c);
        return 32'(adjusted_vel[VW*c +: VW]);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_ph[c]    = P_OFF;
            m_lvl[c]   = 0;
            m_note[c]  = 0;
            m_peak[c]  = 0;
            m_acc[c]   = 0;
            exp_vel[c] = 0;
            exp_act[c] = 0;
        end
    endtask

    // Rate accumulator as plain arithmetic: add 2^rate, step when it overflows 2^TW.
    function automatic bit m_advance(input int c, input int rate);
        int e;
        if (rate == 15) return 1'b1;
        e = (rate > TW - 1) ? TW - 1 : rate;
        m_acc[c] += longint'(1) << e;
        if (m_acc[c] >= (longint'(1) << TW)) begin
            m_acc[c] -= longint'(1) << TW;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_tick();
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            exp_vel[c] = m_lvl[c];
            exp_act[c] = (m_ph[c] != P_OFF) ? 1 : 0;
        end
        if (!en) return;
        for (int c = 0; c < CH; c++) begin
            bit on, rep;
            int nt, vl, tgt;
            on  = note_on[c];
            rep = note_repeat[c];
            nt  = int'(note_start[7*c +: 7]);
            vl  = int'(vel_start[VW*c +: VW]);
            tgt = (int'(sustain) < m_peak[c]) ? int'(sustain) : m_peak[c];
            if (m_ph[c] == P_OFF) begin
                if (on) begin
                    m_ph[c] = P_RISE; m_note[c] = nt; m_peak[c] = vl; m_acc[c] = 0;
                end
            end else if (on && (rep || nt != m_note[c])) begin
                m_ph[c] = P_RISE; m_note[c] = nt; m_peak[c] = vl; m_acc[c] = 0;
            end else if (!on && m_ph[c] != P_FADE) begin
                m_ph[c] = P_FADE; m_acc[c] = 0;
            end else if (m_ph[c] == P_RISE) begin
                if (m_lvl[c] >= m_peak[c]) begin
                    m_ph[c] = P_FALL; m_acc[c] = 0;
                end else if (m_advance(c, int'(attack))) begin
                    m_lvl[c] = (m_lvl[c] + ST < m_peak[c]) ? m_lvl[c] + ST : m_peak[c];
                    if (m_lvl[c] == m_peak[c]) begin
                        m_ph[c] = P_FALL; m_acc[c] = 0;
                    end
                end
            end else if (m_ph[c] == P_FALL) begin
                if (m_lvl[c] <= tgt) begin
                    m_ph[c] = P_HOLD; m_acc[c] = 0;
                end else if (m_advance(c, int'(decay))) begin
                    m_lvl[c] = (m_lvl[c] - ST > tgt) ? m_lvl[c] - ST : tgt;
                    if (m_lvl[c] == tgt) begin
                        m_ph[c] = P_HOLD; m_acc[c] = 0;
                    end
                end
            end else if (m_ph[c] == P_FADE) begin
                if (m_lvl[c] == 0) begin
                    m_ph[c] = P_OFF; m_acc[c] = 0;
                end else if (m_advance(c, int'(release_rate))) begin
                    m_lvl[c] = (m_lvl[c] > ST) ? m_lvl[c] - ST : 0;
                    if (m_lvl[c] == 0) begin
                        m_ph[c] = P_OFF; m_acc[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("vel_ch%0d", c), ch_vel(c), 32'(exp_vel[c]));
            chk($sformatf("active_ch%0d", c), 32'(active[c]), 32'(exp_act[c]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_tick();
            #1;
            check_outputs();
            @(negedge clk);
        end
    endtask

    task automatic set_ch(input int c, input bit on, input int note, input int vel);
        note_on[c]             = on;
        note_start[7*c +: 7]   = 7'(note);
        vel_start[VW*c +: VW]  = VW'(vel);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        note_on = '0;
        model_clear();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b1;
        attack       = 4'hF;
        decay        = 4'hF;
        release_rate = 4'hF;
        sustain      = 7'd40;
        note_on      = '0;
        note_repeat  = '0;
        note_start   = '0;
        vel_start    = '0;
        model_clear();
        @(negedge clk);
        run(2);
        chk("reset_vel", 32'(adjusted_vel), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        rst_n = 1'b1;

        // Fast attack to 100, fast decay to sustain 40.
        set_ch(0, 1'b1, 60, 100);
        run(15);
        chk("attack_peak", ch_vel(0), 32'd100);
        run(8);
        chk("sustain_level", ch_vel(0), 32'd40);
        chk("sustain_active", 32'(active[0]), 32'd1);

        // Release at rate 7: one step every two en cycles.
        release_rate = 4'd7;
        note_on[0]   = 1'b0;
        run(11);
        chk("release_last_step", ch_vel(0), 32'd8);
        chk("release_active_hi", 32'(active[0]), 32'd1);
        run(1);
        chk("release_zero", ch_vel(0), 32'd0);
        chk("release_active_lo", 32'(active[0]), 32'd0);

        // Retrigger ch1 from sustain 40 to a new peak of 120.
        set_ch(1, 1'b1, 50, 80);
        run(30);
        chk("ch1_sustain", ch_vel(1), 32'd40);
        note_repeat[1]   = 1'b1;
        vel_start[13:7]  = 7'd120;
        run(1);
        note_repeat[1] = 1'b0;
        run(11);
        chk("retrig_peak", ch_vel(1), 32'd120);
        chk("retrig_ch0_idle", ch_vel(0), 32'd0);

        // Attack on ch2 qualified by en on one cycle in three.
        set_ch(2, 1'b1, 10, 100);
        for (int i = 0; i < 30; i++) begin
            en = (i % 3 == 0);
            run(1);
        end
        en = 1'b1;
        chk("en_gated_attack", ch_vel(2), 32'd72);

        // Asynchronous reset while every channel is decaying.
        decay   = 4'd7;
        sustain = 7'd8;
        for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 20 + c, 120);
        run(24);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vel", 32'(adjusted_vel), 32'd0);
        chk("async_rst_active", 32'(active), 32'd0);
        model_clear();
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        run(2);
        chk("held_note_reattack", 32'(active), 32'hF);

        // Sustain above peak, then a note change during release.
        do_reset();
        decay        = 4'hF;
        release_rate = 4'hF;
        sustain      = 7'd120;
        set_ch(3, 1'b1, 70, 50);
        run(10);
        chk("sustain_clamped_peak", ch_vel(3), 32'd50);
        note_on[3] = 1'b0;
        run(3);
        set_ch(3, 1'b1, 71, 50);
        run(3);
        chk("release_note_change", ch_vel(3), 32'd42);

        // Random gate, retrigger and velocity traffic.
        do_reset();
        for (int i = 0; i < 640; i++) begin
            if (i % 64 == 0) begin
                attack       = 4'($urandom_range(4, 14));
                decay        = 4'($urandom_range(4, 14));
                release_rate = 4'($urandom_range(4, 14));
                sustain      = VW'($urandom_range(0, 127));
            end
            en = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < CH; c++) begin
                note_repeat[c] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0) note_on[c] = ~note_on[c];
                if ($urandom_range(0, 39) == 0) note_start[7*c +: 7] = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 7) == 0) begin
                    vel_start[VW*c +: VW] = ($urandom_range(0, 3) == 0) ? '0 : VW'($urandom_range(0, 127));
                end
            end
            run(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
